// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe
// Extends an IN_W-bit immediate to OUT_W bits according to extop and
// buffers the result in a DEPTH-entry FIFO with valid/ready handshakes on
// both sides. Results are computed when an offer is accepted and stored,
// so there is no combinational path from the inputs to the outputs.
//
// Configuration macro: IMM_EXT_SHIFT_MODE_EN
//    defined   : extop 011 yields the sign-extension shifted left by 2
//    undefined : extop 011 is treated as unsupported (result 0, illegal=1)
//
// Ports
//    clk        in   single clock, rising edge
//    rst        in   synchronous active-high reset
//    flush      in   synchronous discard of all buffered entries
//    in_valid   in   producer offers imm_in/extop
//    in_ready   out  buffer has room (occupancy < DEPTH)
//    imm_in     in   IN_W immediate
//    extop      in   3-bit extension mode
//    out_valid  out  head entry valid
//    out_ready  in   consumer takes the head entry
//    imm_out    out  OUT_W extended head result (0 when empty)
//    illegal    out  head entry was pushed with an unsupported extop

module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm_in,
   input  logic [2:0]       extop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] imm_out,
   output logic             illegal
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int EXT_W = OUT_W - IN_W;

   logic [OUT_W-1:0] data_q [DEPTH];
   logic [OUT_W-1:0] data_d [DEPTH];
   logic             ill_q  [DEPTH];
   logic             ill_d  [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [OUT_W-1:0] ext_result;
   logic             ext_illegal;
   logic [OUT_W-1:0] sext_value;
   logic             push;
   logic             pop;

   // Extension unit: works on the current offer; its result only reaches the
   // outputs after being written into the buffer.
   always_comb begin
      sext_value  = {{EXT_W{imm_in[IN_W-1]}}, imm_in};
      ext_result  = '0;
      ext_illegal = 1'b0;
      unique case (extop)
         3'b000: ext_result = {{EXT_W{1'b0}}, imm_in};
         3'b001: ext_result = sext_value;
         3'b010: ext_result = {imm_in, {EXT_W{1'b0}}};
`ifdef IMM_EXT_SHIFT_MODE_EN
         // Branch offset: sign-extended immediate in units of 4 bytes.
         3'b011: ext_result = sext_value << 2;
`else
         3'b011: ext_illegal = 1'b1;
`endif
         default: ext_illegal = 1'b1;
      endcase
   end

   // Handshake decode: in_ready depends only on occupancy, so a full buffer
   // refuses an offer even when the head is being popped the same cycle.
   always_comb begin
      in_ready  = (count_q < CNT_W'(DEPTH));
      out_valid = (count_q != '0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      imm_out   = out_valid ? data_q[rd_ptr_q] : '0;
      illegal   = out_valid ? ill_q[rd_ptr_q] : 1'b0;
   end

   // Next-state for the buffer. Flush wins over push and pop and also
   // returns the pointers home so the storage restarts from entry 0.
   always_comb begin
      data_d   = data_q;
      ill_d    = ill_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            data_d[wr_ptr_q] = ext_result;
            ill_d[wr_ptr_q]  = ext_illegal;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // State registers; reset has priority over everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            ill_q[i]  <= 1'b0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
            ill_q[i]  <= ill_d[i];
         end
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe
// Directed-vector bench for imm_ext_pipe at IN_W=16, OUT_W=32, DEPTH=2.
// Expected values are hand-computed constants; extop 011 expectations follow
// whether IMM_EXT_SHIFT_MODE_EN is defined for this compile.

module tb_imm_ext_pipe;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] imm_in;
   logic [2:0]  extop;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] imm_out;
   logic        illegal;

   int vectorCount;
   int missCount;

   imm_ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm_in    (imm_in),
      .extop     (extop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imm_out   (imm_out),
      .illegal   (illegal)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and tally it.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Set the inputs for the next edge, let that edge happen, then settle
   // 1 time unit past it so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic v, input logic [15:0] imm,
                                input logic [2:0] op, input logic ordy,
                                input logic fl, input logic rs);
      in_valid  = v;
      imm_in    = imm;
      extop     = op;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectorCount = 0;
      missCount   = 0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; imm_in = '0; extop = '0; out_ready = 1'b0;
      @(negedge clk);

      // Reset state
      applyStimulus(1'b0, 16'h0, 3'b000, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h0, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_in_ready",  {31'b0, in_ready},  32'd1);
      checkOutput("rst_imm_out",   imm_out,            32'h0);
      checkOutput("rst_illegal",   {31'b0, illegal},   32'd0);

      // Sign then zero extension, back to back with the consumer ready
      applyStimulus(1'b1, 16'h8001, 3'b001, 1'b1, 1'b0, 1'b0);
      checkOutput("sext_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("sext_value", imm_out, 32'hFFFF8001);
      applyStimulus(1'b1, 16'h8001, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("zext_value", imm_out, 32'h00008001);
      checkOutput("zext_illegal", {31'b0, illegal}, 32'd0);
      applyStimulus(1'b0, 16'h0, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("drain_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("drain_imm", imm_out, 32'h0);

      // Upper placement
      applyStimulus(1'b1, 16'h1234, 3'b010, 1'b1, 1'b0, 1'b0);
      checkOutput("upper_value", imm_out, 32'h12340000);
      checkOutput("upper_illegal", {31'b0, illegal}, 32'd0);

      // Branch-offset mode and an unsupported mode
      applyStimulus(1'b1, 16'hFFFF, 3'b011, 1'b1, 1'b0, 1'b0);
`ifdef IMM_EXT_SHIFT_MODE_EN
      checkOutput("shift_value", imm_out, 32'hFFFFFFFC);
      checkOutput("shift_illegal", {31'b0, illegal}, 32'd0);
`else
      checkOutput("shift_value", imm_out, 32'h00000000);
      checkOutput("shift_illegal", {31'b0, illegal}, 32'd1);
`endif
      applyStimulus(1'b1, 16'hFFFF, 3'b101, 1'b1, 1'b0, 1'b0);
      checkOutput("op101_value", imm_out, 32'h00000000);
      checkOutput("op101_illegal", {31'b0, illegal}, 32'd1);
      checkOutput("op101_valid", {31'b0, out_valid}, 32'd1);
      applyStimulus(1'b0, 16'h0, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("empty_illegal", {31'b0, illegal}, 32'd0);

      // Fill with the consumer stalled, then release; pointers wrap
      applyStimulus(1'b1, 16'h0001, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("fill1_in_ready", {31'b0, in_ready}, 32'd1);
      applyStimulus(1'b1, 16'h0002, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("fill2_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("fill2_head", imm_out, 32'h1);
      applyStimulus(1'b1, 16'h0003, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("full_hold_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("full_hold_head", imm_out, 32'h1);
      // Pop while full: the offer of 3 is still refused this edge
      applyStimulus(1'b1, 16'h0003, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("release_head2", imm_out, 32'h2);
      checkOutput("release_ready", {31'b0, in_ready}, 32'd1);
      applyStimulus(1'b1, 16'h0003, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("release_head3", imm_out, 32'h3);
      checkOutput("release_valid3", {31'b0, out_valid}, 32'd1);
      applyStimulus(1'b0, 16'h0, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("release_empty", {31'b0, out_valid}, 32'd0);
      // Pop while empty has no effect
      applyStimulus(1'b0, 16'h0, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("empty_pop_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("empty_pop_ready", {31'b0, in_ready}, 32'd1);

      // Flush with one entry buffered plus a same-cycle push and pop
      applyStimulus(1'b1, 16'h00AA, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("preflush_head", imm_out, 32'h000000AA);
      applyStimulus(1'b1, 16'h0055, 3'b000, 1'b1, 1'b1, 1'b0);
      checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("flush_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("flush_imm", imm_out, 32'h0);
      applyStimulus(1'b0, 16'h0, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("postflush_valid", {31'b0, out_valid}, 32'd0);

      // Reset while full
      applyStimulus(1'b1, 16'h0010, 3'b000, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0020, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("prerst_ready", {31'b0, in_ready}, 32'd0);
      applyStimulus(1'b1, 16'h0030, 3'b001, 1'b1, 1'b1, 1'b1);
      checkOutput("midrst_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midrst_imm", imm_out, 32'h0);
      checkOutput("midrst_ready", {31'b0, in_ready}, 32'd1);
      applyStimulus(1'b0, 16'h0, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("postrst_valid", {31'b0, out_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width.
REQ-002 Parameter OUT_W, default 32, extended result width; SHALL satisfy OUT_W > IN_W.
REQ-003 Parameter DEPTH, default 2, result buffer entries; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 in_valid  input  1  producer offers imm_in/extop this cycle.
REQ-008 in_ready  output  1  block accepts an offer this cycle.
REQ-009 imm_in  input  IN_W  immediate to extend.
REQ-010 extop  input  3  extension mode.
REQ-011 out_valid  output  1  head entry is valid.
REQ-012 out_ready  input  1  consumer takes the head entry this cycle.
REQ-013 imm_out  output  OUT_W  extended result of the head entry.
REQ-014 illegal  output  1  head entry was pushed with an unsupported extop.

Function
REQ-015 extop 000 SHALL produce a zero-extension of imm_in to OUT_W.
REQ-016 extop 001 SHALL produce a sign-extension of imm_in from bit IN_W-1.
REQ-017 extop 010 SHALL place imm_in in the top IN_W bits, with zeros below.
REQ-018 extop 011 SHALL produce the sign-extension shifted left by 2, truncated to OUT_W (branch offset).
REQ-019 extop 100-111 SHALL store result 0 with illegal=1; all supported modes SHALL store illegal=0.
REQ-020 Push SHALL occur when in_valid && in_ready; the result SHALL be computed from that cycle's inputs and stored.
REQ-021 Latency: an entry pushed into an empty buffer in cycle N SHALL appear at out_valid/imm_out in cycle N+1; no combinational input-to-output path.
REQ-022 Pop SHALL occur when out_valid && out_ready.
REQ-023 in_ready SHALL be 1 iff occupancy < DEPTH; when full, it SHALL stay 0 even if a pop occurs that cycle.
REQ-024 Simultaneous push and pop when not full SHALL leave occupancy unchanged.
REQ-025 Order SHALL be strict FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-026 out_valid SHALL be 1 iff occupancy > 0.
REQ-027 When empty, imm_out SHALL be 0 and illegal SHALL be 0.
REQ-028 flush SHALL set occupancy to 0 next cycle and SHALL override a same-cycle push or pop; the offered item is dropped.
REQ-029 A pop while empty and a push while full SHALL have no effect.

Reset
REQ-030 rst SHALL take priority over flush, push and pop.
REQ-031 After rst: occupancy 0, pointers 0, out_valid 0, in_ready 1, imm_out 0, illegal 0.
REQ-032 rst asserted mid-operation SHALL discard all entries at the next edge.

Configuration
REQ-033 Macro IMM_EXT_SHIFT_MODE_EN SHALL control extop 011.
REQ-034 With IMM_EXT_SHIFT_MODE_EN defined, extop 011 SHALL behave per REQ-018.
REQ-035 Without it, extop 011 SHALL be illegal per REQ-019; all other modes SHALL be unchanged.

Verification (IN_W=16, OUT_W=32, DEPTH=2)
REQ-036 Push imm_in=0x8001 with extop=001, then with 000 -> imm_out 0xFFFF8001, then 0x00008001, each one cycle after its push.
REQ-037 Push 0x1234 with extop=010 -> imm_out 0x12340000 and illegal=0.
REQ-038 Push 0xFFFF with extop=011 -> with macro: 0xFFFFFFFC, illegal=0; without macro: 0x00000000, illegal=1; extop=101 -> 0x00000000, illegal=1.
REQ-039 Hold out_ready=0 and offer 0x0001, 0x0002, 0x0003 (extop=000) -> in_ready=0 after two pushes; release out_ready -> outputs 0x1, then 0x2, then 0x3 is accepted and emitted in order.
REQ-040 With 1 entry buffered, assert flush together with in_valid and out_ready -> next cycle out_valid=0, in_ready=1, and the offered item is never output.
REQ-041 Assert rst while full -> next cycle out_valid=0, imm_out=0, in_ready=1.
